// File: rtl/maze_grid_render.sv
// Maze cell store with a two-stage RGB332 pixel renderer and a raster clear sweep.
// Optional cursor tracking (old cursor cell demoted to visited) with `define MAZE_RENDER_CURSOR_EN.
module maze_grid_render #(
  parameter int COLS      = 4,
  parameter int ROWS      = 5,
  parameter int CELL_LOG2 = 6,
  parameter int WALL_PX   = 2
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       UPD_VALID,
  output logic       UPD_READY,
  input  logic [2:0] UPD_X,
  input  logic [2:0] UPD_Y,
  input  logic [2:0] UPD_STATE,
  input  logic [3:0] UPD_WALLS,
  input  logic       CLEAR,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  output logic       BUSY,
  output logic [7:0] DROP_CNT
);
  localparam int NCELL = ROWS * COLS;
  localparam int IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELL - 1);
  localparam logic [CELL_LOG2-1:0] WALL_LO = CELL_LOG2'(WALL_PX);
  localparam logic [CELL_LOG2-1:0] WALL_HI = CELL_LOG2'((1 << CELL_LOG2) - WALL_PX);
  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [9:0] ROWS_W = 10'(ROWS);

`ifdef MAZE_RENDER_CURSOR_EN
  typedef enum logic [1:0] {SWEEP, IDLE, CUR2} state_t;
`else
  typedef enum logic {SWEEP, IDLE} state_t;
`endif

  function automatic logic [IDX_W-1:0] cell_index(input logic [9:0] col, input logic [9:0] row);
    return IDX_W'(row * COLS_W + col);
  endfunction

  logic [6:0]       cells [NCELL];
  state_t           state, state_next;
  logic [IDX_W-1:0] sweep_idx;
  logic [7:0]       drop_cnt;
  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [6:0]       wdata;
  logic             accept;
  logic             upd_ready;
  logic             upd_bad;
  logic [IDX_W-1:0] upd_idx;

  logic [9:0]       pix_col, pix_row;
  logic             pix_in_grid;
  logic [IDX_W-1:0] rd_idx;

  logic [9:0]           s1_col, s1_row;
  logic [CELL_LOG2-1:0] s1_offx, s1_offy;
  logic [6:0]           s1_data;
  logic                 s1_valid;
  logic [7:0]           color_q;
  logic [7:0]           pix_color, state_color;
  logic                 on_border, on_wall;

`ifdef MAZE_RENDER_CURSOR_EN
  logic [2:0]       cur_x, cur_y, pend_x, pend_y;
  logic             cur_valid;
  logic [IDX_W-1:0] cur_idx;
  assign cur_idx = cell_index({7'd0, cur_x}, {7'd0, cur_y});
`endif

  assign upd_bad = ({7'd0, UPD_X} >= COLS_W) || ({7'd0, UPD_Y} >= ROWS_W) || (UPD_STATE == 3'd7);
  assign upd_idx = cell_index({7'd0, UPD_X}, {7'd0, UPD_Y});

  // CLEAR wins over a same-cycle update, so READY drops with it.
  always_comb begin
    state_next = state;
    upd_ready  = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    accept     = 1'b0;
    case (state)
      SWEEP: begin
        we    = 1'b1;
        waddr = sweep_idx;
        if (sweep_idx == LAST_IDX) state_next = IDLE;
      end
      IDLE: begin
        upd_ready = !CLEAR;
        if (CLEAR) begin
          state_next = SWEEP;
        end else if (UPD_VALID) begin
          accept = 1'b1;
          if (!upd_bad) begin
            we    = 1'b1;
            waddr = upd_idx;
            wdata = {UPD_STATE, UPD_WALLS};
`ifdef MAZE_RENDER_CURSOR_EN
            if (UPD_STATE == 3'd6 && cur_valid && cur_idx != upd_idx) state_next = CUR2;
`endif
          end
        end
      end
`ifdef MAZE_RENDER_CURSOR_EN
      CUR2: begin
        we         = 1'b1;
        waddr      = cur_idx;
        wdata      = {3'd1, cells[cur_idx][3:0]};
        state_next = IDLE;
      end
`endif
      default: state_next = SWEEP;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= SWEEP;
      sweep_idx <= '0;
      drop_cnt  <= 8'd0;
    end else begin
      state <= state_next;
      if (state == SWEEP) sweep_idx <= (sweep_idx == LAST_IDX) ? '0 : sweep_idx + 1'b1;
      if (accept && upd_bad && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef MAZE_RENDER_CURSOR_EN
  // The new position waits in pend_* while CUR2 still needs the old one.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_x     <= 3'd0;
      cur_y     <= 3'd0;
      pend_x    <= 3'd0;
      pend_y    <= 3'd0;
      cur_valid <= 1'b0;
    end else if (state == SWEEP) begin
      cur_valid <= 1'b0;
    end else if (state == CUR2) begin
      cur_x <= pend_x;
      cur_y <= pend_y;
    end else if (accept && !upd_bad && UPD_STATE == 3'd6) begin
      if (state_next == CUR2) begin
        pend_x <= UPD_X;
        pend_y <= UPD_Y;
      end else begin
        cur_x     <= UPD_X;
        cur_y     <= UPD_Y;
        cur_valid <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (we) cells[waddr] <= wdata;
  end

  assign pix_col     = PIXEL_X >> CELL_LOG2;
  assign pix_row     = PIXEL_Y >> CELL_LOG2;
  assign pix_in_grid = (pix_col < COLS_W) && (pix_row < ROWS_W);
  assign rd_idx      = pix_in_grid ? cell_index(pix_col, pix_row) : '0;

  always_comb begin
    on_border = (s1_col == 10'd0 && s1_offx < WALL_LO) ||
                (s1_col == COLS_W - 10'd1 && s1_offx >= WALL_HI) ||
                (s1_row == 10'd0 && s1_offy < WALL_LO) ||
                (s1_row == ROWS_W - 10'd1 && s1_offy >= WALL_HI);
    on_wall   = (s1_data[3] && s1_offy < WALL_LO) || (s1_data[2] && s1_offx >= WALL_HI) ||
                (s1_data[1] && s1_offy >= WALL_HI) || (s1_data[0] && s1_offx < WALL_LO);
    case (s1_data[6:4])
      3'd0:    state_color = 8'hFF;
      3'd1:    state_color = 8'hFC;
      3'd2:    state_color = 8'h88;
      3'd3:    state_color = 8'hE0;
      3'd4:    state_color = 8'h1C;
      3'd5:    state_color = 8'h03;
      3'd6:    state_color = 8'h3E;
      default: state_color = 8'h00;
    endcase
    if (!(s1_col < COLS_W && s1_row < ROWS_W)) pix_color = 8'h00;
    else if (on_border || on_wall)             pix_color = 8'h88;
    else                                       pix_color = state_color;
  end

  // A pixel shows only if neither of its pipeline cycles nor the display cycle is busy.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_col   <= 10'd0;
      s1_row   <= 10'd0;
      s1_offx  <= '0;
      s1_offy  <= '0;
      s1_data  <= 7'd0;
      s1_valid <= 1'b0;
      color_q  <= 8'h00;
    end else begin
      s1_col   <= pix_col;
      s1_row   <= pix_row;
      s1_offx  <= PIXEL_X[CELL_LOG2-1:0];
      s1_offy  <= PIXEL_Y[CELL_LOG2-1:0];
      s1_data  <= cells[rd_idx];
      s1_valid <= (state != SWEEP);
      color_q  <= (state == SWEEP || state_next == SWEEP || !s1_valid) ? 8'h00 : pix_color;
    end
  end

  assign UPD_READY   = upd_ready;
  assign BUSY        = (state == SWEEP);
  assign PIXEL_COLOR = color_q;
  assign DROP_CNT    = drop_cnt;

endmodule

// File: tb/tb_maze_grid_render.sv
// Randomised self-checking bench for maze_grid_render against a behavioural map model.
// Define MAZE_RENDER_CURSOR_EN for both bench and RTL to check the cursor build.
module tb_maze_grid_render;
  localparam int COLS      = 4;
  localparam int ROWS      = 5;
  localparam int CELL_LOG2 = 6;
  localparam int WALL_PX   = 2;
  localparam int CELL      = 1 << CELL_LOG2;
  localparam int NCELL     = ROWS * COLS;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       UPD_VALID = 1'b0;
  logic       UPD_READY;
  logic [2:0] UPD_X = 3'd0;
  logic [2:0] UPD_Y = 3'd0;
  logic [2:0] UPD_STATE = 3'd0;
  logic [3:0] UPD_WALLS = 4'd0;
  logic       CLEAR = 1'b0;
  logic [9:0] PIXEL_X = 10'd0;
  logic [9:0] PIXEL_Y = 10'd0;
  logic [7:0] PIXEL_COLOR;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  maze_grid_render #(.COLS(COLS), .ROWS(ROWS), .CELL_LOG2(CELL_LOG2), .WALL_PX(WALL_PX)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .UPD_VALID(UPD_VALID), .UPD_READY(UPD_READY),
    .UPD_X(UPD_X), .UPD_Y(UPD_Y), .UPD_STATE(UPD_STATE), .UPD_WALLS(UPD_WALLS),
    .CLEAR(CLEAR), .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_COLOR(PIXEL_COLOR),
    .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_compared = 0;
  int n_mismatched = 0;
  bit chk_on = 1'b0;

  // Behavioural model: the map as an array, busy as a countdown of sweep cycles.
  logic [6:0] m_cells [NCELL];
  int         m_sweep_left;
  int         m_drop;
  bit         m_cur_valid, m_fix_pending;
  int         m_cur_x, m_cur_y, m_new_x, m_new_y;
  bit         m_p1_ok;
  logic [7:0] m_p1_color, m_exp_color;

  function automatic logic [7:0] ref_color(int px, int py);
    int w, h, ox, oy;
    logic [6:0] c;
    w = COLS * CELL;
    h = ROWS * CELL;
    if (px >= w || py >= h) return 8'h00;
    if (px < WALL_PX || px >= w - WALL_PX || py < WALL_PX || py >= h - WALL_PX) return 8'h88;
    c  = m_cells[(py / CELL) * COLS + px / CELL];
    ox = px % CELL;
    oy = py % CELL;
    if ((c[3] && oy < WALL_PX) || (c[2] && ox >= CELL - WALL_PX) ||
        (c[1] && oy >= CELL - WALL_PX) || (c[0] && ox < WALL_PX)) return 8'h88;
    case (c[6:4])
      3'd0: return 8'hFF;
      3'd1: return 8'hFC;
      3'd2: return 8'h88;
      3'd3: return 8'hE0;
      3'd4: return 8'h1C;
      3'd5: return 8'h03;
      3'd6: return 8'h3E;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_cells[i]) m_cells[i] = 7'd0;
    m_sweep_left  = NCELL;
    m_drop        = 0;
    m_cur_valid   = 1'b0;
    m_fix_pending = 1'b0;
    m_p1_ok       = 1'b0;
    m_p1_color    = 8'h00;
    m_exp_color   = 8'h00;
  endtask

  task automatic model_step();
    bit busy_now;
    logic [7:0] px_color;
    int idx;
    busy_now = (m_sweep_left > 0);
    px_color = ref_color(int'(PIXEL_X), int'(PIXEL_Y));
    if (busy_now) begin
      m_sweep_left--;
    end else if (m_fix_pending) begin
      idx = m_cur_y * COLS + m_cur_x;
      m_cells[idx] = {3'd1, m_cells[idx][3:0]};
      m_cur_x = m_new_x;
      m_cur_y = m_new_y;
      m_fix_pending = 1'b0;
    end else if (CLEAR) begin
      m_sweep_left = NCELL;
      foreach (m_cells[i]) m_cells[i] = 7'd0;
      m_cur_valid = 1'b0;
    end else if (UPD_VALID) begin
      if (int'(UPD_X) >= COLS || int'(UPD_Y) >= ROWS || UPD_STATE == 3'd7) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_cells[int'(UPD_Y) * COLS + int'(UPD_X)] = {UPD_STATE, UPD_WALLS};
`ifdef MAZE_RENDER_CURSOR_EN
        if (UPD_STATE == 3'd6) begin
          if (m_cur_valid && (m_cur_x != int'(UPD_X) || m_cur_y != int'(UPD_Y))) begin
            m_fix_pending = 1'b1;
            m_new_x = int'(UPD_X);
            m_new_y = int'(UPD_Y);
          end else begin
            m_cur_x = int'(UPD_X);
            m_cur_y = int'(UPD_Y);
            m_cur_valid = 1'b1;
          end
        end
`endif
      end
    end
    m_exp_color = (busy_now || m_sweep_left > 0 || !m_p1_ok) ? 8'h00 : m_p1_color;
    m_p1_color  = px_color;
    m_p1_ok     = !busy_now;
  endtask

  always @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) model_reset();
    else          model_step();
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    bit exp_busy;
    exp_busy = (m_sweep_left > 0);
    compare("busy", 32'(BUSY), 32'(exp_busy));
    compare("upd_ready", 32'(UPD_READY), 32'(!exp_busy && !m_fix_pending && !CLEAR));
    compare("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
    compare("pixel_color", 32'(PIXEL_COLOR), 32'(m_exp_color));
  endtask

  always @(negedge CLOCK) if (chk_on) check_output();

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (BUSY && cnt < 200) begin
      cnt++;
      tick(1);
    end
  endtask

  task automatic apply_stimulus(input int x, input int y, input int st, input int w);
    UPD_X     = 3'(x);
    UPD_Y     = 3'(y);
    UPD_STATE = 3'(st);
    UPD_WALLS = 4'(w);
    UPD_VALID = 1'b1;
    tick(1);
    UPD_VALID = 1'b0;
  endtask

  task automatic probe(input string name, input int px, input int py, input logic [7:0] exp);
    PIXEL_X = 10'(px);
    PIXEL_Y = 10'(py);
    tick(2);
    compare(name, 32'(PIXEL_COLOR), 32'(exp));
  endtask

  function automatic int pick_off();
    case ($urandom_range(5))
      0: return 0;
      1: return 1;
      2: return WALL_PX;
      3: return CELL - WALL_PX - 1;
      4: return CELL - 1;
      default: return int'($urandom_range(CELL - 1));
    endcase
  endfunction

  initial begin
    #1_000_000;
    n_mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    int cnt, lows;
    model_reset();
    tick(1);
    chk_on = 1'b1;
    compare("reset_busy", 32'(BUSY), 32'd1);
    compare("reset_ready", 32'(UPD_READY), 32'd0);
    compare("reset_color", 32'(PIXEL_COLOR), 32'h00);
    compare("reset_drop", 32'(DROP_CNT), 32'd0);
    tick(2);
    RESET_N = 1'b1;
    wait_busy(cnt);
    compare("init_busy_cycles", 32'(cnt), 32'd20);
    compare("init_ready", 32'(UPD_READY), 32'd1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        probe("init_cell", c * CELL + CELL / 2, r * CELL + CELL / 2, 8'hFF);
    probe("outside_grid", 300, 10, 8'h00);

    apply_stimulus(1, 2, 3, 4'b0010);
    probe("t7_centre", 96, 160, 8'hE0);
    probe("t7_south_wall", 96, 191, 8'h88);
    probe("t7_above_wall", 96, 189, 8'hE0);
    probe("outer_border", 1, 100, 8'h88);

    apply_stimulus(4, 0, 1, 0);
    apply_stimulus(0, 5, 1, 0);
    apply_stimulus(0, 0, 7, 0);
    compare("drop_three", 32'(DROP_CNT), 32'd3);
    probe("bad_not_written", 32, 32, 8'hFF);

    CLEAR = 1'b1;
    apply_stimulus(5, 0, 1, 0);
    CLEAR = 1'b0;
    compare("clear_drop_unchanged", 32'(DROP_CNT), 32'd3);
    wait_busy(cnt);
    compare("clear_busy_cycles", 32'(cnt), 32'd20);
    probe("clear_wiped", 96, 160, 8'hFF);

    UPD_X = 3'd7;
    UPD_VALID = 1'b1;
    tick(300);
    UPD_VALID = 1'b0;
    compare("drop_saturated", 32'(DROP_CNT), 32'd255);

    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    tick(7);
    RESET_N = 1'b0;
    #1;
    compare("midsweep_busy", 32'(BUSY), 32'd1);
    compare("midsweep_ready", 32'(UPD_READY), 32'd0);
    compare("midsweep_color", 32'(PIXEL_COLOR), 32'h00);
    compare("midsweep_drop", 32'(DROP_CNT), 32'd0);
    tick(3);
    RESET_N = 1'b1;
    wait_busy(cnt);
    compare("restart_busy_cycles", 32'(cnt), 32'd20);

    for (int i = 0; i < 600; i++) begin
      PIXEL_X   = 10'(int'($urandom_range(COLS)) * CELL + pick_off());
      PIXEL_Y   = 10'(int'($urandom_range(ROWS)) * CELL + pick_off());
      UPD_VALID = ($urandom_range(1) == 1);
      UPD_X     = 3'($urandom_range(COLS));
      UPD_Y     = 3'($urandom_range(ROWS));
      UPD_STATE = 3'($urandom_range(7));
      UPD_WALLS = 4'($urandom);
      CLEAR     = ($urandom_range(63) == 0);
      tick(1);
    end
    UPD_VALID = 1'b0;
    CLEAR = 1'b0;
    tick(3);
    wait_busy(cnt);
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    wait_busy(cnt);

    apply_stimulus(0, 0, 6, 0);
    apply_stimulus(2, 3, 6, 0);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (!UPD_READY) lows++;
      tick(1);
    end
`ifdef MAZE_RENDER_CURSOR_EN
    compare("cursor_ready_low", 32'(lows), 32'd1);
    probe("cursor_old_cell", 32, 32, 8'hFC);
`else
    compare("cursor_ready_low", 32'(lows), 32'd0);
    probe("cursor_old_cell", 32, 32, 8'h3E);
`endif
    probe("cursor_new_cell", 160, 224, 8'h3E);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/maze_grid_render.md
MAZE_GRID_RENDER -- requirements
Module: maze_grid_render

Interface
REQ-001 Parameter COLS, default 4, maze columns (1..8).
REQ-002 Parameter ROWS, default 5, maze rows (1..8).
REQ-003 Parameter CELL_LOG2, default 6, log2 of cell edge in pixels (cell = 64 px).
REQ-004 Parameter WALL_PX, default 2, wall stripe thickness in pixels, less than half the cell edge.
REQ-005 Port CLOCK in 1 -- single clock; all state SHALL be clocked on its rising edge.
REQ-006 Port RESET_N in 1 -- asynchronous, active-low reset.
REQ-007 Port UPD_VALID in 1 -- cell update request.
REQ-008 Port UPD_READY out 1 -- update accepted on any cycle with UPD_VALID and UPD_READY both high.
REQ-009 Port UPD_X in 3 and UPD_Y in 3 -- target cell column and row.
REQ-010 Port UPD_STATE in 3 -- cell code: 0 unvisited, 1 visited, 2 wall, 3 treasure7, 4 treasure12, 5 treasure17, 6 current, 7 reserved.
REQ-011 Port UPD_WALLS in 4 -- wall bits {N,E,S,W}.
REQ-012 Port CLEAR in 1 -- single-cycle request to blank the map.
REQ-013 Port PIXEL_X in 10 and PIXEL_Y in 10 -- coordinates from the VGA driver.
REQ-014 Port PIXEL_COLOR out 8 -- RGB332 colour for the pixel presented two cycles earlier.
REQ-015 Port BUSY out 1 -- high while an init or clear sweep is in progress.
REQ-016 Port DROP_CNT out 8 -- saturating count of rejected updates.

Function
REQ-017 The block SHALL hold a ROWS*COLS cell store; each entry is 7 bits, {state[2:0], walls[3:0]}.
REQ-018 FSM states: SWEEP, IDLE, and, with the Configuration feature only, CUR2.
REQ-019 SWEEP SHALL write {0,4'b0000} to one cell per cycle in raster order, keep UPD_READY low and BUSY high, and go to IDLE after the last cell (ROWS*COLS cycles).
REQ-020 IDLE SHALL drive UPD_READY high; CLEAR high in IDLE SHALL enter SWEEP on the next cycle, and CLEAR SHALL take priority over a simultaneous update, which is not accepted.
REQ-021 An accepted update with UPD_X>=COLS, UPD_Y>=ROWS or UPD_STATE=7 SHALL write nothing and increment DROP_CNT, saturating at 255.
REQ-022 An accepted in-range update SHALL write its cell on the acceptance edge.
REQ-023 Render stage 1 SHALL register the cell index (PIXEL_X>>CELL_LOG2, PIXEL_Y>>CELL_LOG2), the in-cell offsets (low CELL_LOG2 bits) and the store read.
REQ-024 Render stage 2 SHALL register PIXEL_COLOR, giving a fixed latency of 2 cycles.
REQ-025 A pixel read and an update to the same cell in the same cycle SHALL return the old contents.
REQ-026 Colour priority, highest first:
- outside the grid -> 8'h00
- outer maze border, WALL_PX wide -> 8'h88
- offset within WALL_PX of a side whose wall bit is set -> 8'h88
- otherwise the state colour: 0 FF, 1 FC, 2 88, 3 E0, 4 1C, 5 03, 6 3E
REQ-027 PIXEL_COLOR SHALL be 8'h00 whenever BUSY is high.

Reset
REQ-028 While RESET_N is low, the block SHALL hold: UPD_READY=0, BUSY=1, PIXEL_COLOR=8'h00, DROP_CNT=0, both pipeline stages cleared, FSM=SWEEP at cell 0.
REQ-029 RESET_N asserted mid-sweep or mid-update SHALL abort the operation; the sweep restarts from cell 0 after release.

Configuration
REQ-030 With MAZE_RENDER_CURSOR_EN defined:
- the block SHALL keep a cursor register (CUR_X, CUR_Y, valid flag), cleared by reset and by sweep;
- an accepted state-6 update SHALL write the new cell and, if the cursor is valid and points elsewhere, enter CUR2;
- CUR2 SHALL hold UPD_READY low for one cycle while it rewrites the old cursor cell's state to 1, keeping its walls, then return to IDLE;
- the cursor register SHALL then move to the new cell.
REQ-031 Without MAZE_RENDER_CURSOR_EN, state 6 SHALL be stored like any other code and there is no CUR2 state.

Verification
REQ-032 Release reset, wait 20 cycles: BUSY falls on cycle 20, UPD_READY rises, all in-grid pixels read FF, pixel (300,10) reads 00.
REQ-033 Update x=1 y=2 state=3 walls=0010: pixel (96,160) reads E0 after 2 cycles; (96,191) reads 88; (96,189) reads E0.
REQ-034 Update x=4 y=0, then x=0 y=5, then state 7: nothing is written and DROP_CNT reads 3; 300 further bad updates leave DROP_CNT at 255.
REQ-035 Drive CLEAR and UPD_VALID on the same cycle: the update is not accepted, BUSY is high for 20 cycles, then every cell reads FF.
REQ-036 Cursor build: state 6 to (0,0), then state 6 to (2,3): UPD_READY is low for exactly one cycle, (0,0) reads FC and (2,3) reads 3E.
REQ-037 Pulse RESET_N low during a sweep at cell 7: outputs take reset values at once, and the sweep restarts at cell 0 and completes 20 cycles after release.
